hilo_unit: RTL and testbench
============================

HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of operands, HI and LO.
REQ-002 SHALL have parameter MUL_LATENCY, default 3, legal range 1..8: cycles from multiply acceptance to HI/LO write.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port op_valid  input  1  op is presented this cycle.
REQ-006 SHALL have port op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-ops.
REQ-007 SHALL have port rs_value  input  WIDTH  operand A, dividend, or MTHI/MTLO source.
REQ-008 SHALL have port rt_value  input  WIDTH  operand B or divisor.
REQ-009 SHALL have port is_mf_hi, is_mf_lo  input  1 each  decode-stage MFHI/MFLO flags.
REQ-010 SHALL have port instr_rs_value  input  WIDTH  normal rs operand.
REQ-011 SHALL have port actual_rs_value  output  WIDTH  rs operand after HI/LO substitution.
REQ-012 SHALL have port reg_hi, reg_lo  output  WIDTH each  architectural HI and LO.
REQ-013 SHALL have port busy  output  1  multiply or divide in flight.
REQ-014 SHALL have port stall  output  1  combinational stall request to decode.

Function
REQ-015 SHALL accept an op at edge E0 only when op_valid=1, busy=0 and op is 0..5.
  - Ops presented while busy=1 are not accepted.
  - Upstream holds an unaccepted op.
REQ-016 SHALL write MTHI/MTLO to HI/LO at E0; busy stays 0; the other register is unchanged.
REQ-017 SHALL implement an FSM with states IDLE, MUL and DIV.
  - IDLE->MUL on accepted MULT/MULTU; IDLE->DIV on accepted DIV/DIVU.
  - MUL/DIV->IDLE at the completion edge EN.
REQ-018 SHALL hold busy=1 from after E0 through EN, and busy=0 after EN.
  - Multiply: EN=E0+MUL_LATENCY.
  - Divide: EN=E0+WIDTH+1 (WIDTH restoring shift-subtract iterations, then one sign-fixup cycle).
REQ-019 SHALL compute the multiply product as 2*WIDTH bits: MULT signed, MULTU unsigned; at EN, HI=upper WIDTH bits, LO=lower WIDTH bits.
REQ-020 SHALL compute the divide with LO=quotient truncated toward zero and HI=remainder carrying the dividend's sign; DIVU is unsigned.
REQ-021 SHALL handle a zero divisor by completing at E0+1 with HI and LO unchanged.
REQ-022 SHALL handle signed DIV of the most negative value by -1 as LO=most negative value, HI=0.
REQ-023 SHALL capture operands at E0, so later changes on rs_value/rt_value do not affect the result.
REQ-024 SHALL drive actual_rs_value as follows:
  - reg_hi if is_mf_hi=1; is_mf_hi wins when both flags are set.
  - reg_lo if only is_mf_lo=1.
  - instr_rs_value otherwise.
REQ-025 SHALL assert stall=busy&(is_mf_hi|is_mf_lo|(op_valid&(op<=5))).
REQ-026 SHALL make a value written at edge E visible on actual_rs_value in the cycle after E; there is no same-cycle bypass.

Reset
REQ-027 SHALL, while rst_n=0 and regardless of clk, force:
  - reg_hi=0, reg_lo=0, busy=0, stall=0, FSM=IDLE;
  - the iteration counter and operand registers to 0.
REQ-028 SHALL abort any in-flight multiply/divide when reset asserts mid-operation; HI/LO stay 0 after release.
REQ-029 SHALL accept a new op on the first rising edge after rst_n deasserts.

Verification (WIDTH=32, MUL_LATENCY=3)
REQ-030 SHALL cover: MULTU rs=0xFFFFFFFF rt=2 -> busy for 3 cycles, then HI=0x00000001, LO=0xFFFFFFFE.
REQ-031 SHALL cover: MULT rs=0xFFFFFFFD(-3) rt=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1 at E0+3.
REQ-032 SHALL cover: DIV rs=0xFFFFFFF9(-7) rt=2 -> busy 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2.
REQ-033 SHALL cover: MFLO with is_mf_lo=1 during a divide -> stall=1 every busy cycle, stall=0 and actual_rs_value=new LO in the cycle after EN.
REQ-034 SHALL cover: DIV rt=0 with prior HI=0x11, LO=0x22 -> busy one cycle, HI=0x11, LO=0x22 unchanged.
REQ-035 SHALL cover: rst_n pulled low at iteration 10 of a divide -> immediately busy=0, HI=LO=0; then MTLO 0x5A after release -> LO=0x5A, busy=0.

Source files
------------

// File: rtl/hilo_unit.sv
// hilo_unit: MIPS-style HI/LO register unit with a multi-cycle multiplier and
// a restoring divider, plus decode-stage MFHI/MFLO operand substitution.
//
// Ports:
//   clk, rst_n       - clock (rising edge) and asynchronous active-low reset
//   op_valid, op     - operation request: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU,
//                      4 MTHI, 5 MTLO, 6/7 no-op
//   rs_value         - operand A / dividend / MTHI-MTLO source
//   rt_value         - operand B / divisor
//   is_mf_hi/lo      - decode-stage MFHI/MFLO flags
//   instr_rs_value   - normal rs operand
//   actual_rs_value  - rs operand after HI/LO substitution
//   reg_hi, reg_lo   - architectural HI and LO
//   busy             - multiply or divide in flight
//   stall            - combinational stall request to decode
module hilo_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_value,
  input  logic [WIDTH-1:0] rt_value,
  input  logic             is_mf_hi,
  input  logic             is_mf_lo,
  input  logic [WIDTH-1:0] instr_rs_value,
  output logic [WIDTH-1:0] actual_rs_value,
  output logic [WIDTH-1:0] reg_hi,
  output logic [WIDTH-1:0] reg_lo,
  output logic             busy,
  output logic             stall
);

  localparam int unsigned CntW = ($clog2(WIDTH + 1) > 4) ? $clog2(WIDTH + 1) : 4;

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
  // a_q: multiplicand, or dividend magnitude shifting into the quotient.
  // b_q: multiplier, or divisor magnitude.
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, r_q, r_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d;

  logic [2*WIDTH-1:0] ext_a, ext_b, product;
  logic [WIDTH:0]     rem_shift, diff;
  logic               div_sgn;

  // Low 2*WIDTH bits of the product of sign/zero-extended operands are exact.
  always_comb begin
    ext_a   = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
    ext_b   = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
    product = ext_a * ext_b;
  end

  always_comb begin
    rem_shift = {r_q, a_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, b_q};
  end

  assign div_sgn = (op == OpDiv);

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    unique case (state_q)
      StIdle: begin
        if (op_valid) begin
          case (op)
            OpMult, OpMultu: begin
              a_d     = rs_value;
              b_d     = rt_value;
              sgn_d   = (op == OpMult);
              cnt_d   = CntW'(MUL_LATENCY - 1);
              state_d = StMul;
            end
            OpDiv, OpDivu: begin
              a_d     = (div_sgn & rs_value[WIDTH-1]) ? -rs_value : rs_value;
              b_d     = (div_sgn & rt_value[WIDTH-1]) ? -rt_value : rt_value;
              r_d     = '0;
              cnt_d   = '0;
              sgn_d   = div_sgn;
              qneg_d  = div_sgn & (rs_value[WIDTH-1] ^ rt_value[WIDTH-1]);
              rneg_d  = div_sgn & rs_value[WIDTH-1];
              state_d = StDiv;
            end
            OpMthi:  hi_d = rs_value;
            OpMtlo:  lo_d = rs_value;
            default: ;
          endcase
        end
      end
      StMul: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = product;
          state_d      = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDiv: begin
        if (b_q == '0) begin
          // Zero divisor: finish after one busy cycle, HI/LO untouched.
          state_d = StIdle;
        end else if (cnt_q == CntW'(WIDTH)) begin
          lo_d    = qneg_q ? -a_q : a_q;
          hi_d    = rneg_q ? -r_q : r_q;
          state_d = StIdle;
        end else begin
          if (!diff[WIDTH]) begin
            r_d = diff[WIDTH-1:0];
            a_d = {a_q[WIDTH-2:0], 1'b1};
          end else begin
            r_d = rem_shift[WIDTH-1:0];
            a_d = {a_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign reg_hi = hi_q;
  assign reg_lo = lo_q;
  assign busy   = (state_q != StIdle);
  assign stall  = busy & (is_mf_hi | is_mf_lo | (op_valid & (op <= OpMtlo)));

  // Registered HI/LO only: a write becomes visible the cycle after it lands.
  always_comb begin
    if (is_mf_hi)      actual_rs_value = hi_q;
    else if (is_mf_lo) actual_rs_value = lo_q;
    else               actual_rs_value = instr_rs_value;
  end

endmodule

// File: tb/tb_hilo_unit.sv
module tb_hilo_unit;

  localparam int unsigned W  = 32;
  localparam int unsigned ML = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          op_valid;
  logic [2:0]    op;
  logic [W-1:0]  rs_value, rt_value, instr_rs_value;
  logic          is_mf_hi, is_mf_lo;
  logic [W-1:0]  actual_rs_value, reg_hi, reg_lo;
  logic          busy, stall;

  hilo_unit #(.WIDTH(W), .MUL_LATENCY(ML)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .op_valid        (op_valid),
    .op              (op),
    .rs_value        (rs_value),
    .rt_value        (rt_value),
    .is_mf_hi        (is_mf_hi),
    .is_mf_lo        (is_mf_lo),
    .instr_rs_value  (instr_rs_value),
    .actual_rs_value (actual_rs_value),
    .reg_hi          (reg_hi),
    .reg_lo          (reg_lo),
    .busy            (busy),
    .stall           (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_hi, m_lo;
  int           total = 0;
  int           bad = 0;

  // Reference model: updates the bench's HI/LO copy and queues the expectation.
  task automatic push_model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    longint       sa, sbv;
    logic [63:0]  p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    e.cyc = ML;
    case (o)
      3'd0: begin p = 64'(sa * sbv); m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: begin
        e.cyc = (b == 0) ? 1 : W + 1;
        if (b != 0) begin m_lo = W'(sa / sbv); m_hi = W'(sa % sbv); end
      end
      default: begin
        e.cyc = (b == 0) ? 1 : W + 1;
        if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      end
    endcase
    e.hi = m_hi;
    e.lo = m_lo;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    op_valid = 1'b1; op = o; rs_value = a; rt_value = b;
    @(posedge clk);
    #1;
    op_valid = 1'b0; op = 3'd7;
    rs_value = $urandom; rt_value = $urandom;  // captured operands must not follow these
  endtask

  // Counts busy cycles after E0 (bounded); returns -1 if busy never drops.
  task automatic wait_idle(output int cyc, output int stall_lo);
    bit done;
    done = 1'b0; cyc = 0; stall_lo = 0;
    while (!done && cyc <= 100) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
      else begin
        cyc++;
        if (!stall) stall_lo++;
      end
    end
    if (!done) cyc = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; op_valid = 1'b1; op = 3'd0; is_mf_hi = 1'b1; is_mf_lo = 1'b0;
    rs_value = 32'h1234; rt_value = 32'h5; instr_rs_value = 32'hABCD_0123;
    #23;
    total++; if (reg_hi !== 0) begin bad++; $display("FAIL reset_hi got %h want 0", reg_hi); end
    total++; if (reg_lo !== 0) begin bad++; $display("FAIL reset_lo got %h want 0", reg_lo); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got %b want 0", stall); end
    total++; if (actual_rs_value !== 0) begin bad++; $display("FAIL reset_rs got %h want 0", actual_rs_value); end
    op_valid = 1'b0; is_mf_hi = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul;
    exp_t e;
    int   cyc, sl;
    push_model(3'd1, 32'hFFFF_FFFF, 32'd2);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_idle(cyc, sl);
    e = sb.pop_front();
    total++; if (cyc !== e.cyc || cyc !== 3) begin bad++; $display("FAIL multu_busy got %0d want 3", cyc); end
    total++; if (reg_hi !== e.hi || reg_hi !== 32'h1) begin bad++; $display("FAIL multu_hi got %h want 00000001", reg_hi); end
    total++; if (reg_lo !== e.lo || reg_lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_lo got %h want fffffffe", reg_lo); end
    push_model(3'd0, 32'hFFFF_FFFD, 32'd5);
    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    wait_idle(cyc, sl);
    e = sb.pop_front();
    total++; if (cyc !== 3) begin bad++; $display("FAIL mult_busy got %0d want 3", cyc); end
    total++; if (reg_hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got %h want ffffffff", reg_hi); end
    total++; if (reg_lo !== 32'hFFFF_FFF1 || reg_lo !== e.lo) begin bad++; $display("FAIL mult_lo got %h want fffffff1", reg_lo); end
  endtask

  task automatic test_div;
    exp_t e;
    int   cyc, sl;
    push_model(3'd2, 32'hFFFF_FFF9, 32'd2);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(cyc, sl);
    e = sb.pop_front();
    total++; if (cyc !== 33) begin bad++; $display("FAIL div_busy got %0d want 33", cyc); end
    total++; if (reg_lo !== 32'hFFFF_FFFD || reg_lo !== e.lo) begin bad++; $display("FAIL div_lo got %h want fffffffd", reg_lo); end
    total++; if (reg_hi !== 32'hFFFF_FFFF || reg_hi !== e.hi) begin bad++; $display("FAIL div_hi got %h want ffffffff", reg_hi); end
    push_model(3'd3, 32'd100, 32'd7);
    issue(3'd3, 32'd100, 32'd7);
    wait_idle(cyc, sl);
    e = sb.pop_front();
    total++; if (reg_lo !== 32'd14) begin bad++; $display("FAIL divu_lo got %h want 0000000e", reg_lo); end
    total++; if (reg_hi !== 32'd2) begin bad++; $display("FAIL divu_hi got %h want 00000002", reg_hi); end
    // Most negative / -1.
    push_model(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(cyc, sl);
    e = sb.pop_front();
    total++; if (reg_lo !== 32'h8000_0000 || reg_lo !== e.lo) begin bad++; $display("FAIL divmin_lo got %h want 80000000", reg_lo); end
    total++; if (reg_hi !== 32'h0) begin bad++; $display("FAIL divmin_hi got %h want 0", reg_hi); end
  endtask

  task automatic test_div_zero;
    exp_t e;
    int   cyc, sl;
    issue(3'd4, 32'h11, 32'h0);
    issue(3'd5, 32'h22, 32'h0);
    m_hi = 32'h11; m_lo = 32'h22;
    push_model(3'd2, 32'h1234_5678, 32'h0);
    issue(3'd2, 32'h1234_5678, 32'h0);
    wait_idle(cyc, sl);
    e = sb.pop_front();
    total++; if (cyc !== 1) begin bad++; $display("FAIL divzero_busy got %0d want 1", cyc); end
    total++; if (reg_hi !== 32'h11 || reg_hi !== e.hi) begin bad++; $display("FAIL divzero_hi got %h want 00000011", reg_hi); end
    total++; if (reg_lo !== 32'h22 || reg_lo !== e.lo) begin bad++; $display("FAIL divzero_lo got %h want 00000022", reg_lo); end
  endtask

  task automatic test_mf_stall;
    exp_t e;
    int   cyc, sl;
    instr_rs_value = 32'hDEAD_BEEF;
    is_mf_lo = 1'b1;
    push_model(3'd3, 32'd1000, 32'd9);
    issue(3'd3, 32'd1000, 32'd9);
    wait_idle(cyc, sl);
    e = sb.pop_front();
    total++; if (cyc !== 33) begin bad++; $display("FAIL mflo_busy got %0d want 33", cyc); end
    total++; if (sl !== 0) begin bad++; $display("FAIL mflo_stall_gap got %0d cycles low want 0", sl); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL mflo_stall_after got %b want 0", stall); end
    total++; if (actual_rs_value !== e.lo || actual_rs_value !== 32'd111) begin bad++; $display("FAIL mflo_value got %h want 0000006f", actual_rs_value); end
    is_mf_lo = 1'b0;
  endtask

  task automatic test_forwarding;
    // MTHI is not bypassed: old HI visible before the edge, new one after.
    is_mf_hi = 1'b1;
    @(negedge clk);
    op_valid = 1'b1; op = 3'd4; rs_value = 32'h0BAD_F00D;
    #1;
    total++; if (actual_rs_value !== m_hi) begin bad++; $display("FAIL nobypass got %h want %h", actual_rs_value, m_hi); end
    @(posedge clk); #1;
    op_valid = 1'b0;
    m_hi = 32'h0BAD_F00D;
    @(negedge clk);
    total++; if (actual_rs_value !== m_hi) begin bad++; $display("FAIL mfhi_next got %h want %h", actual_rs_value, m_hi); end
    is_mf_lo = 1'b1; #1;
    total++; if (actual_rs_value !== m_hi) begin bad++; $display("FAIL mf_both got %h want %h", actual_rs_value, m_hi); end
    is_mf_hi = 1'b0; #1;
    total++; if (actual_rs_value !== m_lo) begin bad++; $display("FAIL mf_lo_only got %h want %h", actual_rs_value, m_lo); end
    is_mf_lo = 1'b0; #1;
    total++; if (actual_rs_value !== instr_rs_value) begin bad++; $display("FAIL mf_none got %h want %h", actual_rs_value, instr_rs_value); end
  endtask

  task automatic test_back_to_back;
    // An MTHI held while busy must wait for the multiply to retire.
    exp_t e;
    int   cyc, sl;
    push_model(3'd0, 32'h0001_0003, 32'h0002_0005);
    issue(3'd0, 32'h0001_0003, 32'h0002_0005);
    op_valid = 1'b1; op = 3'd4; rs_value = 32'hCAFE_BABE;
    wait_idle(cyc, sl);
    e = sb.pop_front();
    total++; if (cyc !== 3 || sl !== 0) begin bad++; $display("FAIL hold_busy got %0d/%0d want 3/0", cyc, sl); end
    total++; if (reg_hi !== e.hi) begin bad++; $display("FAIL hold_hi_early got %h want %h", reg_hi, e.hi); end
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd7;
    m_hi = 32'hCAFE_BABE;
    @(negedge clk);
    total++; if (reg_hi !== m_hi) begin bad++; $display("FAIL hold_hi_late got %h want %h", reg_hi, m_hi); end
    total++; if (reg_lo !== e.lo || busy !== 1'b0) begin bad++; $display("FAIL hold_lo got %h/%b want %h/0", reg_lo, busy, e.lo); end
  endtask

  task automatic test_random;
    exp_t         e;
    int           cyc, sl;
    logic [2:0]   o;
    logic [W-1:0] a, b;
    for (int i = 0; i < 10; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 3 == 0) ? W'($urandom_range(0, 20)) : $urandom;
      if (i % 4 == 1) b = -b;
      push_model(o, a, b);
      issue(o, a, b);
      wait_idle(cyc, sl);
      e = sb.pop_front();
      total++;
      if (cyc !== e.cyc || reg_hi !== e.hi || reg_lo !== e.lo) begin
        bad++;
        $display("FAIL rand%0d op=%0d a=%h b=%h got %0d/%h/%h want %0d/%h/%h",
                 i, o, a, b, cyc, reg_hi, reg_lo, e.cyc, e.hi, e.lo);
      end
    end
  endtask

  task automatic test_reset_mid;
    issue(3'd2, 32'h7FFF_0000, 32'd3);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got %b want 0", busy); end
    total++; if (reg_hi !== 0 || reg_lo !== 0) begin bad++; $display("FAIL midrst_hilo got %h/%h want 0/0", reg_hi, reg_lo); end
    @(negedge clk);
    rst_n = 1'b1;
    op_valid = 1'b1; op = 3'd5; rs_value = 32'h5A;
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd7;
    @(negedge clk);
    total++; if (reg_lo !== 32'h5A) begin bad++; $display("FAIL postrst_lo got %h want 0000005a", reg_lo); end
    total++; if (busy !== 1'b0 || reg_hi !== 0) begin bad++; $display("FAIL postrst_state got %b/%h want 0/0", busy, reg_hi); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_mf_stall();
    test_forwarding();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
